// File: rtl/reg_status_file_if.sv
// ID/ROB-facing bundle of the register status file: commit stream, rename
// request, two source read ports and the busy count.
interface reg_status_file_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned TAG_W = 5
);
  logic              flush;
  logic [TAG_W-1:0]  wb_tag;
  logic [RW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              ren_en;
  logic [RW-1:0]     ren_rd;
  logic [TAG_W-1:0]  ren_tag;
  logic [RW-1:0]     rs1_idx;
  logic [RW-1:0]     rs2_idx;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [TAG_W-1:0]  rs1_tag;
  logic [TAG_W-1:0]  rs2_tag;
  logic [RW:0]       busy_cnt;

  modport master (
    output flush, wb_tag, wb_rd, wb_data, ren_en, ren_rd, ren_tag, rs1_idx, rs2_idx,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_cnt
  );

  modport slave (
    input  flush, wb_tag, wb_rd, wb_data, ren_en, ren_rd, ren_tag, rs1_idx, rs2_idx,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_cnt
  );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing
// ROB tag); commit writes data, rename marks pending, flush clears all pending.
module reg_status_file #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREG        = 32,
  parameter int unsigned RW          = 5,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned TAG_INVALID = 31
) (
  input logic               clk,
  input logic               rst,
  reg_status_file_if.slave  bus
);
  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(TAG_INVALID);
  localparam int unsigned      CNT_W   = RW + 1;

  logic [XLEN-1:0]  r_data [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;
  logic [CNT_W-1:0] r_busy_cnt;

  logic             w_commit;
  logic             w_clr;
  logic             w_ren;
  logic             w_inc;
  logic             w_dec;
  logic [NREG-1:0]  w_busy_nxt;
  logic             w_byp1;
  logic             w_byp2;

  // Commit clears status only when the register still waits on this tag.
  assign w_commit = (bus.wb_tag != TAG_INV) && (bus.wb_rd != '0);
  assign w_clr    = w_commit && r_busy[bus.wb_rd] && (r_tag[bus.wb_rd] == bus.wb_tag);
  assign w_ren    = bus.ren_en && (bus.ren_rd != '0) && !bus.flush;
  assign w_inc    = w_ren && !r_busy[bus.ren_rd];
  assign w_dec    = w_clr && !(w_ren && (bus.ren_rd == bus.wb_rd));

  // Rename overrides a same-cycle clear; flush overrides everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[bus.wb_rd] = 1'b0;
    if (w_ren) w_busy_nxt[bus.ren_rd] = 1'b1;
    if (bus.flush) w_busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= TAG_INV;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_commit) r_data[bus.wb_rd] <= bus.wb_data;
      for (int i = 0; i < NREG; i++) begin
        if (bus.flush)                                    r_tag[i] <= TAG_INV;
        else if (w_ren && (bus.ren_rd == RW'(i)))         r_tag[i] <= bus.ren_tag;
        else if (w_clr && (bus.wb_rd == RW'(i)))          r_tag[i] <= TAG_INV;
      end
      r_busy <= w_busy_nxt;
      if (bus.flush) r_busy_cnt <= '0;
      else           r_busy_cnt <= r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  // Read ports forward a matching commit so ID never misses a same-cycle result.
  assign w_byp1 = (bus.wb_tag != TAG_INV) && (bus.rs1_idx == bus.wb_rd) && (bus.rs1_idx != '0)
                  && r_busy[bus.rs1_idx] && (r_tag[bus.rs1_idx] == bus.wb_tag);
  assign w_byp2 = (bus.wb_tag != TAG_INV) && (bus.rs2_idx == bus.wb_rd) && (bus.rs2_idx != '0)
                  && r_busy[bus.rs2_idx] && (r_tag[bus.rs2_idx] == bus.wb_tag);

  always_comb begin
    bus.rs1_data = r_data[bus.rs1_idx];
    bus.rs1_busy = r_busy[bus.rs1_idx];
    bus.rs1_tag  = r_busy[bus.rs1_idx] ? r_tag[bus.rs1_idx] : TAG_INV;
    if (bus.rs1_idx == '0) begin
      bus.rs1_data = '0;
      bus.rs1_busy = 1'b0;
      bus.rs1_tag  = TAG_INV;
    end else if (w_byp1) begin
      bus.rs1_data = bus.wb_data;
      bus.rs1_busy = 1'b0;
      bus.rs1_tag  = TAG_INV;
    end
  end

  always_comb begin
    bus.rs2_data = r_data[bus.rs2_idx];
    bus.rs2_busy = r_busy[bus.rs2_idx];
    bus.rs2_tag  = r_busy[bus.rs2_idx] ? r_tag[bus.rs2_idx] : TAG_INV;
    if (bus.rs2_idx == '0) begin
      bus.rs2_data = '0;
      bus.rs2_busy = 1'b0;
      bus.rs2_tag  = TAG_INV;
    end else if (w_byp2) begin
      bus.rs2_data = bus.wb_data;
      bus.rs2_busy = 1'b0;
      bus.rs2_tag  = TAG_INV;
    end
  end
endmodule

// File: tb/tb_reg_status_file.sv
// Scenario bench for reg_status_file: expectations and observed snapshots are
// queued at each sample point and compared at the end of every scenario.
module tb_reg_status_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_status_file_if bus ();

  reg_status_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        busy;
    logic [4:0]  tag;
    logic [5:0]  cnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } entry_t;

  entry_t exp_q [$];
  entry_t obs_q [$];
  int n_run  = 0;
  int n_fail = 0;

  always @(posedge clk)
    if (!rst && bus.ren_en) assert (bus.ren_tag != 5'd31) else $error("ren_tag is TAG_INVALID");

  function automatic obs_t observe(input int port);
    obs_t o;
    if (port == 1) o = {bus.rs1_data, bus.rs1_busy, bus.rs1_tag, bus.busy_cnt};
    else           o = {bus.rs2_data, bus.rs2_busy, bus.rs2_tag, bus.busy_cnt};
    return o;
  endfunction

  // Settle, then queue the expectation and a snapshot of the chosen read port.
  task automatic sample(input string n, input int port, input logic [31:0] d,
                        input logic b, input logic [4:0] t, input logic [5:0] c);
    entry_t e;
    entry_t s;
    #1;
    e.name = n; e.v = {d, b, t, c};
    s.name = n; s.v = observe(port);
    exp_q.push_back(e);
    obs_q.push_back(s);
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.ren_en = 1'b0; bus.ren_rd = '0; bus.ren_tag = 5'd0;
    bus.wb_tag = 5'd31; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] tag);
    bus.ren_en = 1'b1; bus.ren_rd = rd; bus.ren_tag = tag;
  endtask

  task automatic commit(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_tag = tag; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic test_reset();
    entry_t e, o;
    idle(); rename(5'd5, 5'd3); step(); idle();
    bus.rs1_idx = 5'd5;
    sample("rst_pre_busy", 1, 32'h0, 1'b1, 5'd3, 6'd1);
    #1 rst = 1'b1;
    sample("rst_async", 1, 32'h0, 1'b0, 5'd31, 6'd0);
    @(negedge clk) rst = 1'b0;
    step();
    sample("rst_after", 1, 32'h0, 1'b0, 5'd31, 6'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_rename_commit();
    entry_t e, o;
    idle(); rename(5'd5, 5'd3); step(); idle();
    bus.rs1_idx = 5'd5;
    sample("ren_busy", 1, 32'h0, 1'b1, 5'd3, 6'd1);
    commit(5'd3, 5'd5, 32'hDEADBEEF);
    sample("commit_bypass", 1, 32'hDEADBEEF, 1'b0, 5'd31, 6'd1);
    step(); idle();
    sample("commit_stored", 1, 32'hDEADBEEF, 1'b0, 5'd31, 6'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_stale_commit();
    entry_t e, o;
    idle(); rename(5'd7, 5'd2); step();
    rename(5'd7, 5'd6); step(); idle();
    bus.rs2_idx = 5'd7;
    sample("rerename_cnt", 2, 32'h0, 1'b1, 5'd6, 6'd1);
    commit(5'd2, 5'd7, 32'h11);
    sample("stale_no_bypass", 2, 32'h0, 1'b1, 5'd6, 6'd1);
    step(); idle();
    sample("stale_data", 2, 32'h11, 1'b1, 5'd6, 6'd1);
    commit(5'd6, 5'd7, 32'h22);
    sample("young_bypass", 2, 32'h22, 1'b0, 5'd31, 6'd1);
    step(); idle();
    sample("young_stored", 2, 32'h22, 1'b0, 5'd31, 6'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_same_cycle();
    entry_t e, o;
    idle(); rename(5'd9, 5'd1); step();
    rename(5'd9, 5'd4); commit(5'd1, 5'd9, 32'h55);
    bus.rs1_idx = 5'd9; bus.rs2_idx = 5'd9;
    sample("same_cyc_read_old", 1, 32'h55, 1'b0, 5'd31, 6'd1);
    step(); idle();
    sample("same_cyc_rs1", 1, 32'h55, 1'b1, 5'd4, 6'd1);
    sample("same_cyc_rs2", 2, 32'h55, 1'b1, 5'd4, 6'd1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_flush();
    entry_t e, o;
    idle(); rename(5'd1, 5'd1); step();
    rename(5'd2, 5'd2); step();
    rename(5'd3, 5'd3); step(); idle();
    bus.rs1_idx = 5'd3;
    sample("pre_flush_cnt", 1, 32'h0, 1'b1, 5'd3, 6'd4);
    bus.flush = 1'b1; rename(5'd4, 5'd8); commit(5'd1, 5'd1, 32'h77);
    bus.rs2_idx = 5'd1;
    sample("flush_cyc_bypass", 2, 32'h77, 1'b0, 5'd31, 6'd4);
    step(); idle();
    bus.rs1_idx = 5'd1; bus.rs2_idx = 5'd4;
    sample("flush_r1", 1, 32'h77, 1'b0, 5'd31, 6'd0);
    sample("flush_r4_dropped", 2, 32'h0, 1'b0, 5'd31, 6'd0);
    bus.rs1_idx = 5'd9;
    sample("flush_r9", 1, 32'h55, 1'b0, 5'd31, 6'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_reg0();
    entry_t e, o;
    idle(); rename(5'd10, 5'd7); step();
    rename(5'd0, 5'd5); commit(5'd5, 5'd0, 32'hFF);
    bus.rs1_idx = 5'd0; bus.rs2_idx = 5'd10;
    sample("r0_comb", 1, 32'h0, 1'b0, 5'd31, 6'd1);
    step(); idle();
    sample("r0_after", 1, 32'h0, 1'b0, 5'd31, 6'd1);
    sample("r10_busy", 2, 32'h0, 1'b1, 5'd7, 6'd1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    entry_t e, o;
    idle();
    for (int i = 0; i < 6; i++) begin
      rename(5'(16 + i), 5'(11 + i)); step();
      bus.rs1_idx = 5'(16 + i);
      sample("b2b_rename", 1, 32'h0, 1'b1, 5'(11 + i), 6'(2 + i));
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      commit(5'(11 + i), 5'(16 + i), 32'(257 * (i + 1)));
      bus.rs1_idx = 5'(16 + i);
      sample("b2b_bypass", 1, 32'(257 * (i + 1)), 1'b0, 5'd31, 6'(7 - i));
      step();
      sample("b2b_stored", 1, 32'(257 * (i + 1)), 1'b0, 5'd31, 6'(6 - i));
    end
    idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
      if (o.v !== e.v) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b tag=%0d cnt=%0d, want data=%h busy=%b tag=%0d cnt=%0d",
                 e.name, o.v.data, o.v.busy, o.v.tag, o.v.cnt, e.v.data, e.v.busy, e.v.tag, e.v.cnt);
      end
    end
  endtask

  initial begin
    idle();
    bus.rs1_idx = '0; bus.rs2_idx = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_reg0();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status table, sitting between ROB commit and the ID stage.
- Consumes the ROB commit stream (rd, data, tag) and writes committed results.
- Records which ROB tag will produce each register when ID allocates an entry.
- Gives ID two source operands, each as either a committed value or the pending ROB tag to snoop on the broadcast bus.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; register 0 hardwired to zero.
- RW, 5, register index width (log2 NREG).
- TAG_W, 5, ROB tag width.
- TAG_INVALID, 31, tag value meaning "no commit this cycle".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush from jump/branch commit; clears all pending status.
- wb_tag  in  TAG_W  committing ROB tag; TAG_INVALID = no commit.
- wb_rd  in  RW  destination of the committing instruction.
- wb_data  in  XLEN  committed value.
- ren_en  in  1  ID allocates a ROB entry that writes ren_rd.
- ren_rd  in  RW  destination being renamed.
- ren_tag  in  TAG_W  ROB tag allocated to ren_rd.
- rs1_idx, rs2_idx  in  RW  source register indices.
- rs1_data, rs2_data  out  XLEN  committed value; valid when busy=0.
- rs1_busy, rs2_busy  out  1  source pending in ROB.
- rs1_tag, rs2_tag  out  TAG_W  producing tag when busy=1, else TAG_INVALID.
- busy_cnt  out  RW+1  number of registers currently busy.

Behaviour:
- State per register: data[XLEN], busy, tag[TAG_W].
- Reset, asynchronous: all data=0, busy=0, tag=TAG_INVALID, busy_cnt=0.
- Outputs rsN_* reset with the state because they are combinational from it.
- All state updates happen on the rising clk edge.
- Commit (wb_tag != TAG_INVALID and wb_rd != 0):
  - data[wb_rd] <= wb_data unconditionally.
  - If busy[wb_rd] and tag[wb_rd]==wb_tag, set busy<=0 and tag<=TAG_INVALID.
  - If the tag does not match (register renamed again by a younger instruction), busy/tag are unchanged.
- Rename (ren_en, ren_rd != 0, flush=0): busy[ren_rd] <= 1, tag[ren_rd] <= ren_tag.
- Rename and commit to the same rd in one cycle:
  - Data is written.
  - Rename wins for busy/tag, so busy=1 and tag=ren_tag.
- Flush: at the next edge every busy <= 0 and tag <= TAG_INVALID.
  - A rename in the flush cycle is dropped.
  - A commit in the flush cycle still writes data.
- Register 0 reads data=0, busy=0, tag=TAG_INVALID; writes and renames to it are ignored.
- Read ports are combinational, zero latency.
- Commit bypass: if wb_tag != TAG_INVALID, rsN_idx==wb_rd != 0, busy[rsN_idx]=1 and tag==wb_tag, then rsN_data=wb_data, busy=0, tag=TAG_INVALID in the same cycle.
- Same-cycle rename is not visible on the read ports. ID reads sources before its own destination is renamed, so "add r3,r3,r1" sees the old r3 status.
- busy_cnt is a registered count of busy bits, updated each edge consistently with the rules above (+1, -1, 0 or -1 for net change; set to 0 on flush).
  - Re-renaming an already busy register does not change the count.
- Illegal conditions: wb_tag or ren_tag values other than TAG_INVALID and below the ROB depth are not checked. The bench asserts ren_tag != TAG_INVALID when ren_en=1.

Test Plan:
- Reset with rst pulsed mid-cycle while r5 is busy -> immediately rs1_idx=5 gives data=0, busy=0, tag=31; busy_cnt=0.
- Rename r5 tag 3; next cycle read r5 -> busy=1, tag=3. Then commit wb_tag=3, rd=5, data=0xDEADBEEF -> same cycle read gives data=0xDEADBEEF, busy=0 (bypass). Following cycle stored data matches, busy_cnt=0.
- Stale commit: rename r7 tag 2, then r7 tag 6; commit tag 2 with data 0x11 -> r7 data=0x11, busy=1, tag=6. Commit tag 6 with data 0x22 -> data=0x22, busy=0.
- Same-cycle rename and commit of r9: rename tag 4 while committing tag 1, data 0x55 -> next cycle data=0x55, busy=1, tag=4.
- Flush with r1, r2, r3 busy, plus a simultaneous rename of r4 and commit of r1 with data 0x77 -> next cycle all busy=0, r4 not busy, r1 data=0x77, busy_cnt=0.
- Register 0: rename r0 tag 5 and commit rd=0 with data 0xFF -> r0 reads 0, busy=0, busy_cnt unchanged.
